// File: rtl/dm_pkg.sv
// dm_pkg: definitions shared by the data-memory load path, store path and decoder.
//   - load op encodings (LW..LWR, 7 reserved)
//   - byte / half lane constants
//   - word-address slice and alignment helpers
//   - load unit FSM state encoding
package dm_pkg;

   typedef enum logic [2:0] {
      OP_LW  = 3'd0,
      OP_LH  = 3'd1,
      OP_LHU = 3'd2,
      OP_LB  = 3'd3,
      OP_LBU = 3'd4,
      OP_LWL = 3'd5,
      OP_LWR = 3'd6,
      OP_RSV = 3'd7
   } dm_op_e;

   // Byte lane k = addr[1:0]; byte k occupies bits [8k+7:8k] (little-endian)
   localparam logic [1:0] B0 = 2'd0;
   localparam logic [1:0] B1 = 2'd1;
   localparam logic [1:0] B2 = 2'd2;
   localparam logic [1:0] B3 = 2'd3;
   // Half select = addr[1]; H1 is bits [31:16]
   localparam logic       H0 = 1'b0;
   localparam logic       H1 = 1'b1;

   localparam int WADDR_MSB = 31;
   localparam int WADDR_LSB = 2;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_READ = 2'd1,
      ST_RESP = 2'd2
   } ld_state_e;

   function automatic logic [31:0] word_addr(input logic [31:0] addr);
      return {addr[WADDR_MSB:WADDR_LSB], 2'b00};
   endfunction

   // Address error: misaligned LW / LH / LHU, or the reserved op
   function automatic logic ld_addr_err(input dm_op_e op, input logic [1:0] off);
      logic err;
      err = 1'b0;
      case (op)
         OP_LW:         err = (off != B0);
         OP_LH, OP_LHU: err = off[0];
         OP_RSV:        err = 1'b1;
         default:       err = 1'b0;
      endcase
      return err;
   endfunction

endpackage

// File: rtl/dm_load_align.sv
// dm_load_align: combinational load aligner.
//   i_word   : word read from data memory
//   i_rt_old : current rt value (merged into LWL/LWR results)
//   i_off    : byte offset addr[1:0]
//   i_op     : load op (dm_op_e encoding)
//   o_data   : extracted / extended / merged write-back value
module dm_load_align
   import dm_pkg::*;
(
   input  logic [31:0] i_word,
   input  logic [31:0] i_rt_old,
   input  logic [1:0]  i_off,
   input  logic [2:0]  i_op,
   output logic [31:0] o_data
);

   logic [4:0]  w_rsh;
   logic [4:0]  w_lsh;
   logic [31:0] w_shr;
   logic [15:0] w_half;

   // Right shift brings byte k to lane 0; left shift by (3-k) bytes puts
   // byte 0 of memory at the top for LWL. (3-k) == ~k on two bits.
   assign w_rsh  = {i_off, 3'b000};
   assign w_lsh  = {~i_off, 3'b000};
   assign w_shr  = i_word >> w_rsh;
   assign w_half = (i_off[1] == H1) ? i_word[31:16] : i_word[15:0];

   always_comb begin
      o_data = i_word;
      case (dm_op_e'(i_op))
         OP_LB:  o_data = {{24{w_shr[7]}}, w_shr[7:0]};
         OP_LBU: o_data = {24'd0, w_shr[7:0]};
         OP_LH:  o_data = {{16{w_half[15]}}, w_half};
         OP_LHU: o_data = {16'd0, w_half};
         // Memory bytes k..0 fill the top; the low (3-k) bytes keep rt_old
         OP_LWL: o_data = (i_word << w_lsh) | (i_rt_old & ~(32'hFFFF_FFFF << w_lsh));
         // Memory bytes 3..k fill the bottom; the high k bytes keep rt_old
         OP_LWR: o_data = w_shr | (i_rt_old & ~(32'hFFFF_FFFF >> w_rsh));
         default: o_data = i_word;
      endcase
   end

endmodule

// File: rtl/dm_load_unit.sv
// dm_load_unit: MEM-stage load unit in front of the asynchronous-read data memory.
//   clk, reset   : clock, synchronous active-high reset
//   req_*        : load request (valid/ready), byte address, op, rt_old, tag
//   mem_rd_en    : read strobe, high for WAIT_CYCLES+1 cycles per valid load
//   mem_addr     : word-aligned read address
//   mem_rdata    : read data, combinational with mem_addr
//   rsp_*        : write-back response (valid/ready), data, tag, address error
// One request in flight; req_ready is only high in IDLE.
module dm_load_unit
   import dm_pkg::*;
#(
   parameter int WAIT_CYCLES = 0
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [31:0] req_addr,
   input  logic [2:0]  req_op,
   input  logic [31:0] req_rt_old,
   input  logic [4:0]  req_tag,
   output logic        mem_rd_en,
   output logic [31:0] mem_addr,
   input  logic [31:0] mem_rdata,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_data,
   output logic [4:0]  rsp_tag,
   output logic        rsp_exc
);

   ld_state_e   r_state;
   logic [3:0]  r_cnt;
   logic [1:0]  r_off;
   logic [2:0]  r_op;
   logic [31:0] r_rt_old;
   logic        r_req_ready;
   logic        r_rd_en;
   logic [31:0] r_mem_addr;
   logic        r_rsp_valid;
   logic [31:0] r_rsp_data;
   logic [4:0]  r_rsp_tag;
   logic        r_rsp_exc;
   logic [31:0] w_aligned;

   dm_load_align u_align (
      .i_word   (mem_rdata),
      .i_rt_old (r_rt_old),
      .i_off    (r_off),
      .i_op     (r_op),
      .o_data   (w_aligned)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= ST_IDLE;
         r_cnt       <= 4'd0;
         r_off       <= 2'd0;
         r_op        <= 3'd0;
         r_rt_old    <= 32'd0;
         r_req_ready <= 1'b1;
         r_rd_en     <= 1'b0;
         r_mem_addr  <= 32'd0;
         r_rsp_valid <= 1'b0;
         r_rsp_data  <= 32'd0;
         r_rsp_tag   <= 5'd0;
         r_rsp_exc   <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (req_valid) begin
                  r_off       <= req_addr[1:0];
                  r_op        <= req_op;
                  r_rt_old    <= req_rt_old;
                  r_rsp_tag   <= req_tag;
                  r_req_ready <= 1'b0;
                  if (ld_addr_err(dm_op_e'(req_op), req_addr[1:0])) begin
                     // No memory access; the response is ready immediately
                     r_rsp_exc  <= 1'b1;
                     r_rsp_data <= 32'd0;
                     r_state    <= ST_RESP;
                  end else begin
                     r_rsp_exc  <= 1'b0;
                     r_mem_addr <= word_addr(req_addr);
                     r_rd_en    <= 1'b1;
                     r_cnt      <= 4'(WAIT_CYCLES);
                     r_state    <= ST_READ;
                  end
               end
            end
            ST_READ: begin
               if (r_cnt == 4'd0) begin
                  r_rsp_data  <= w_aligned;
                  r_rd_en     <= 1'b0;
                  r_rsp_valid <= 1'b1;
                  r_state     <= ST_RESP;
               end else begin
                  r_cnt <= r_cnt - 4'd1;
               end
            end
            ST_RESP: begin
               // An exception enters RESP straight from IDLE with rsp_valid
               // still low; raising it here gives an error response the same
               // accept-to-valid latency as a zero-wait load.
               if (!r_rsp_valid) begin
                  r_rsp_valid <= 1'b1;
               end else if (rsp_ready) begin
                  r_rsp_valid <= 1'b0;
                  r_req_ready <= 1'b1;
                  r_state     <= ST_IDLE;
               end
            end
            default: begin
               r_state     <= ST_IDLE;
               r_req_ready <= 1'b1;
               r_rd_en     <= 1'b0;
               r_rsp_valid <= 1'b0;
            end
         endcase
      end
   end

   assign req_ready = r_req_ready;
   assign mem_rd_en = r_rd_en;
   assign mem_addr  = r_mem_addr;
   assign rsp_valid = r_rsp_valid;
   assign rsp_data  = r_rsp_data;
   assign rsp_tag   = r_rsp_tag;
   assign rsp_exc   = r_rsp_exc;

endmodule

// File: tb/tb_dm_load_unit.sv
// Bench for dm_load_unit: instance 0 with WAIT_CYCLES=0, instance 1 with
// WAIT_CYCLES=3. Expected responses are queued at issue time and compared
// when the response handshake happens.
module tb_dm_load_unit;

   localparam logic [31:0] WORD = 32'h8899_AABC;
   localparam logic [31:0] OLD  = 32'h1122_3344;
   localparam logic [2:0] LW = 3'd0, LH = 3'd1, LHU = 3'd2, LB = 3'd3,
                          LBU = 3'd4, LWL = 3'd5, LWR = 3'd6, RSV = 3'd7;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset      [2];
   logic        req_valid  [2];
   logic        req_ready  [2];
   logic [31:0] req_addr   [2];
   logic [2:0]  req_op     [2];
   logic [31:0] req_rt_old [2];
   logic [4:0]  req_tag    [2];
   logic        mem_rd_en  [2];
   logic [31:0] mem_addr   [2];
   logic [31:0] mem_rdata  [2];
   logic        rsp_valid  [2];
   logic        rsp_ready  [2];
   logic [31:0] rsp_data   [2];
   logic [4:0]  rsp_tag    [2];
   logic        rsp_exc    [2];

   // Memory: word at 0x10 is WORD; elsewhere 0xDEAD_<addr[15:0]>
   assign mem_rdata[0] = (mem_addr[0] == 32'h10) ? WORD : {16'hDEAD, mem_addr[0][15:0]};
   assign mem_rdata[1] = (mem_addr[1] == 32'h10) ? WORD : {16'hDEAD, mem_addr[1][15:0]};

   dm_load_unit #(.WAIT_CYCLES(0)) u_dut0 (
      .clk(clk), .reset(reset[0]),
      .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_addr(req_addr[0]),
      .req_op(req_op[0]), .req_rt_old(req_rt_old[0]), .req_tag(req_tag[0]),
      .mem_rd_en(mem_rd_en[0]), .mem_addr(mem_addr[0]), .mem_rdata(mem_rdata[0]),
      .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]), .rsp_data(rsp_data[0]),
      .rsp_tag(rsp_tag[0]), .rsp_exc(rsp_exc[0])
   );

   dm_load_unit #(.WAIT_CYCLES(3)) u_dut1 (
      .clk(clk), .reset(reset[1]),
      .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_addr(req_addr[1]),
      .req_op(req_op[1]), .req_rt_old(req_rt_old[1]), .req_tag(req_tag[1]),
      .mem_rd_en(mem_rd_en[1]), .mem_addr(mem_addr[1]), .mem_rdata(mem_rdata[1]),
      .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]), .rsp_data(rsp_data[1]),
      .rsp_tag(rsp_tag[1]), .rsp_exc(rsp_exc[1])
   );

   typedef struct {
      logic [4:0]  tag;
      logic [31:0] data;
      logic        exc;
      logic [31:0] waddr;
      int          rd;
   } exp_t;

   exp_t sb0[$];
   exp_t sb1[$];
   exp_t mon_e;
   int   rdc [2];
   int   errs   = 0;
   int   checks = 0;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   function automatic int sb_size(input int u);
      return (u == 0) ? sb0.size() : sb1.size();
   endfunction

   // Response monitor: samples on the falling edge
   always @(negedge clk) begin
      for (int u = 0; u < 2; u++) begin
         if (!reset[u] && mem_rd_en[u]) begin
            rdc[u]++;
            if (sb_size(u) > 0) begin
               mon_e = (u == 0) ? sb0[0] : sb1[0];
               chk($sformatf("mem_addr%0d", u), mem_addr[u], mon_e.waddr);
            end else begin
               chk($sformatf("rd_en_no_req%0d", u), 32'(mem_rd_en[u]), 32'd0);
            end
         end
         if (!reset[u] && rsp_valid[u] && rsp_ready[u]) begin
            if (sb_size(u) == 0) begin
               chk($sformatf("unexpected_rsp%0d", u), 32'(rsp_valid[u]), 32'd0);
            end else begin
               mon_e = (u == 0) ? sb0.pop_front() : sb1.pop_front();
               chk($sformatf("rsp_data%0d", u), rsp_data[u], mon_e.data);
               chk($sformatf("rsp_tag%0d", u),  32'(rsp_tag[u]), 32'(mon_e.tag));
               chk($sformatf("rsp_exc%0d", u),  32'(rsp_exc[u]), 32'(mon_e.exc));
               chk($sformatf("rd_cycles%0d", u), rdc[u], mon_e.rd);
            end
         end
      end
   end

   // Called at posedge+#1. Issues one load; if wait_rsp, returns once
   // rsp_valid is seen and checks accept-to-valid latency.
   task automatic send(input int u, input logic [2:0] op, input logic [31:0] addr,
                       input logic [31:0] old, input logic [4:0] tag,
                       input logic [31:0] exp_data, input logic exp_exc, input bit wait_rsp);
      exp_t e;
      int   n;
      int   lat;
      n = 0;
      while (!req_ready[u] && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
      if (n >= 100) chk("ready_timeout", 32'(req_ready[u]), 32'd1);
      e.tag   = tag;
      e.data  = exp_data;
      e.exc   = exp_exc;
      e.waddr = {addr[31:2], 2'b00};
      e.rd    = exp_exc ? 0 : ((u == 0) ? 1 : 4);
      if (u == 0) sb0.push_back(e); else sb1.push_back(e);
      req_valid[u]  = 1'b1;
      req_addr[u]   = addr;
      req_op[u]     = op;
      req_rt_old[u] = old;
      req_tag[u]    = tag;
      @(posedge clk); #1;
      req_valid[u] = 1'b0;
      rdc[u] = 0;
      if (wait_rsp) begin
         lat = 0;
         while (!rsp_valid[u] && lat < 50) begin
            chk("busy_ready", 32'(req_ready[u]), 32'd0);
            @(posedge clk); #1;
            lat++;
         end
         chk($sformatf("latency%0d_op%0d", u, op), lat, (exp_exc || u == 0) ? 1 : 4);
      end
   endtask

   task automatic check_reset_vals(input int u, input string tag);
      chk({tag, "_req_ready"}, 32'(req_ready[u]), 32'd1);
      chk({tag, "_mem_rd_en"}, 32'(mem_rd_en[u]), 32'd0);
      chk({tag, "_mem_addr"},  mem_addr[u],       32'd0);
      chk({tag, "_rsp_valid"}, 32'(rsp_valid[u]), 32'd0);
      chk({tag, "_rsp_data"},  rsp_data[u],       32'd0);
      chk({tag, "_rsp_tag"},   32'(rsp_tag[u]),   32'd0);
      chk({tag, "_rsp_exc"},   32'(rsp_exc[u]),   32'd0);
   endtask

   initial begin
      for (int u = 0; u < 2; u++) begin
         reset[u] = 1'b1; req_valid[u] = 1'b0; req_addr[u] = '0; req_op[u] = '0;
         req_rt_old[u] = '0; req_tag[u] = '0; rsp_ready[u] = 1'b1; rdc[u] = 0;
      end
      repeat (2) @(posedge clk);
      #1;
      check_reset_vals(0, "rst0");
      check_reset_vals(1, "rst1");
      reset[0] = 1'b0; reset[1] = 1'b0;
      @(posedge clk); #1;

      // Extraction / extension / merge on the zero-wait unit
      send(0, LB,  32'h13, OLD, 5'd1,  32'hFFFF_FF88, 1'b0, 1'b1);
      send(0, LBU, 32'h12, OLD, 5'd2,  32'h0000_0099, 1'b0, 1'b1);
      send(0, LH,  32'h12, OLD, 5'd3,  32'hFFFF_8899, 1'b0, 1'b1);
      send(0, LHU, 32'h10, OLD, 5'd4,  32'h0000_AABC, 1'b0, 1'b1);
      send(0, LW,  32'h10, OLD, 5'd5,  32'h8899_AABC, 1'b0, 1'b1);
      send(0, LWL, 32'h10, OLD, 5'd6,  32'hBC22_3344, 1'b0, 1'b1);
      send(0, LWL, 32'h12, OLD, 5'd7,  32'h99AA_BC44, 1'b0, 1'b1);
      send(0, LWR, 32'h11, OLD, 5'd8,  32'h1188_99AA, 1'b0, 1'b1);
      send(0, LWR, 32'h13, OLD, 5'd9,  32'h1122_3388, 1'b0, 1'b1);
      send(0, LWL, 32'h13, OLD, 5'd10, 32'h8899_AABC, 1'b0, 1'b1);
      send(0, LWR, 32'h10, OLD, 5'd11, 32'h8899_AABC, 1'b0, 1'b1);
      send(0, LB,  32'h24, OLD, 5'd12, 32'h0000_0024, 1'b0, 1'b1);
      // Address errors and reserved op
      send(0, LW,  32'h11, OLD, 5'd13, 32'h0, 1'b1, 1'b1);
      send(0, LH,  32'h13, OLD, 5'd14, 32'h0, 1'b1, 1'b1);
      send(0, RSV, 32'h10, OLD, 5'd15, 32'h0, 1'b1, 1'b1);

      // Reset and req_valid together: reset wins, nothing accepted
      repeat (2) @(posedge clk);
      #1;
      reset[0] = 1'b1; req_valid[0] = 1'b1; req_addr[0] = 32'h10;
      req_op[0] = LW; req_tag[0] = 5'd20;
      @(posedge clk); #1;
      reset[0] = 1'b0; req_valid[0] = 1'b0;
      check_reset_vals(0, "rst_vs_req");
      @(posedge clk); #1;
      chk("rst_vs_req_no_rd", 32'(mem_rd_en[0]), 32'd0);
      chk("rst_vs_req_no_rsp", 32'(rsp_valid[0]), 32'd0);

      // Wait states with a stalled consumer
      rsp_ready[1] = 1'b0;
      send(1, LW, 32'h10, OLD, 5'd17, WORD, 1'b0, 1'b1);
      for (int i = 0; i < 5; i++) begin
         chk("stall_valid", 32'(rsp_valid[1]), 32'd1);
         chk("stall_data",  rsp_data[1], WORD);
         chk("stall_tag",   32'(rsp_tag[1]), 32'd17);
         chk("stall_exc",   32'(rsp_exc[1]), 32'd0);
         chk("stall_ready", 32'(req_ready[1]), 32'd0);
         chk("stall_rd_en", 32'(mem_rd_en[1]), 32'd0);
         @(posedge clk); #1;
      end
      rsp_ready[1] = 1'b1;
      send(1, LWR, 32'h12, OLD, 5'd18, 32'h1122_8899, 1'b0, 1'b1);
      send(1, LH,  32'h11, OLD, 5'd19, 32'h0, 1'b1, 1'b1);

      // Reset during READ
      send(1, LW, 32'h10, OLD, 5'd21, WORD, 1'b0, 1'b0);
      @(posedge clk); #1;
      reset[1] = 1'b1;
      sb1.delete();
      @(posedge clk); #1;
      check_reset_vals(1, "rst_read");
      reset[1] = 1'b0;

      // Reset during RESP
      rsp_ready[1] = 1'b0;
      send(1, LBU, 32'h11, OLD, 5'd22, 32'h0000_00AA, 1'b0, 1'b1);
      reset[1] = 1'b1;
      sb1.delete();
      @(posedge clk); #1;
      check_reset_vals(1, "rst_resp");
      reset[1] = 1'b0;
      rsp_ready[1] = 1'b1;

      // Normal completion after the resets
      send(1, LB, 32'h12, OLD, 5'd23, 32'hFFFF_FF99, 1'b0, 1'b1);

      repeat (4) @(posedge clk);
      #1;
      chk("sb0_empty", sb0.size(), 32'd0);
      chk("sb1_empty", sb1.size(), 32'd0);
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

   // Global watchdog
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/dm_load_unit.md
# dm_load_unit

Load-side counterpart of the data memory's byte-enable / unaligned store path. Accepts a load request from the MEM stage, reads the addressed word from the asynchronous-read data memory, and returns the register write-back value. The value is extracted, sign- or zero-extended, or merged for LWL/LWR, using the same little-endian byte layout the store path writes. Sits between the MEM-stage pipeline register and the data memory read port, with valid/ready handshakes on both sides of the pipeline.

## Interface
Parameters:
- WAIT_CYCLES, 0, extra memory wait states inserted before sampling mem_rdata (0..15)

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- req_valid  in  1  load request present
- req_ready  out  1  unit can accept a request
- req_addr  in  32  byte address
- req_op  in  3  LW=0, LH=1, LHU=2, LB=3, LBU=4, LWL=5, LWR=6 (7 reserved)
- req_rt_old  in  32  current rt value, used for LWL/LWR merge
- req_tag  in  5  destination register number
- mem_rd_en  out  1  read strobe to data memory
- mem_addr  out  32  word-aligned address, {addr[31:2],2'b00}
- mem_rdata  in  32  data memory read word, combinational with mem_addr
- rsp_valid  out  1  response present
- rsp_ready  in  1  consumer accepts response
- rsp_data  out  32  write-back value
- rsp_tag  out  5  echoed req_tag
- rsp_exc  out  1  address-error: LW with addr[1:0]≠0, LH/LHU with addr[0]=1, or reserved op

## Operation
- FSM states: IDLE, READ, RESP.
- IDLE: req_ready=1. On req_valid, latch addr/op/rt_old/tag.
  - Misaligned or reserved op: go to RESP with exc=1 and data=0. No memory read occurs.
  - Otherwise go to READ and load wait counter = WAIT_CYCLES.
- READ: mem_rd_en=1 and mem_addr driven from the latched address.
  - Counter decrements each cycle.
  - When the counter is 0, sample mem_rdata through the aligner into the response register and go to RESP.
- RESP: rsp_valid=1, with data, tag and exc held stable. On rsp_ready, go to IDLE.
- Byte lane k = addr[1:0]; byte k is bits [8k+7:8k] (little-endian, matching the store path).
- LW: word unchanged.
- LB/LBU: byte k, sign- or zero-extended to 32 bits.
- LH/LHU: half addr[1] (bits [31:16] if addr[1]=1), sign- or zero-extended.
- LWL, offset k: upper (k+1) bytes of the result = mem bytes k..0; remaining low bytes from rt_old.
  - Example k=0: {m[7:0], old[23:0]}. Example k=3: m.
- LWR, offset k: lower (4−k) bytes of the result = mem bytes 3..k; remaining high bytes from rt_old.
  - Example k=0: m. Example k=3: {old[31:8], m[31:24]}.
- A new request is never accepted while READ or RESP is in progress; req_ready=0 outside IDLE.

## Timing
- Reset values: state=IDLE, req_ready=1, mem_rd_en=0, mem_addr=0, rsp_valid=0, rsp_data=0, rsp_tag=0, rsp_exc=0.
- Latency, accept edge to rsp_valid high:
  - Normal load: WAIT_CYCLES+1 cycles.
  - Exception: 1 cycle.
- mem_rd_en is high for exactly WAIT_CYCLES+1 cycles per accepted valid load.
- rsp_valid holds until rsp_ready. Response fields may not change while rsp_valid=1 and rsp_ready=0.
- Throughput: one request per (latency + 1 + response stall) cycles. Minimum is WAIT_CYCLES+2 cycles per load with rsp_ready tied high.
- Reset asserted in READ or RESP: next edge forces IDLE and reset values. The pending response is dropped and no rsp_valid pulse is emitted.
- Reset and req_valid in the same cycle: reset wins and the request is not accepted.

## Structure
- Shared package dm_pkg holds:
  - the op encodings (LW..LWR)
  - byte/half field constants (B0..B3, H0/H1)
  - the word-address slice
- These are shared with the store path and the decoder.
- Sub-module dm_load_align: purely combinational. Inputs word, rt_old, addr[1:0], op; output aligned/merged data.
- The FSM, counter and response register stay in dm_load_unit.

## Test plan
- mem word 0x8899AABC at 0x10, WAIT_CYCLES=0.
  - LB 0x13 → rsp_data 0xFFFFFF88.
  - LBU 0x12 → 0x00000099.
  - rsp_valid exactly 1 cycle after accept.
- Same word: LH 0x12 → 0xFFFF8899; LHU 0x10 → 0x0000AABC; LW 0x10 → 0x8899AABC.
- rt_old=0x11223344, same word:
  - LWL 0x10 → 0xBC223344; LWL 0x12 → 0x99AABC44.
  - LWR 0x11 → 0x118899AA; LWR 0x13 → 0x11223388.
- LW 0x11 and LH 0x13 → rsp_exc=1, rsp_data=0, mem_rd_en never asserted, rsp_valid 1 cycle after accept.
- WAIT_CYCLES=3, rsp_ready low for 5 cycles:
  - mem_rd_en high exactly 4 cycles.
  - Response held stable until rsp_ready.
  - req_ready=0 throughout.
  - rsp_tag echoes 5'd17.
- Reset pulsed during READ, and again during RESP → all outputs at reset values the next cycle. The next request completes normally.
